// File: rtl/stk_pkg.sv
// Shared definitions for the stack-pointer unit: operation codes and the
// burst-sequencing FSM state type.
package stk_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PULL = 3'd1;
    localparam logic [2:0] OP_PUSH = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_LOAD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_PULL = 2'd2
    } stk_state_e;

endpackage

// File: rtl/stk_wrap_add.sv
// Window-bounded adder. Adds a DBW-bit two's-complement operand to a base
// value. If the sum leaves [STK_LO, STK_HI], it is folded back into the
// window modulo the window size. The operand sign says which edge was
// crossed. Callers pick the folded result or hold, depending on their
// wrap policy.
module stk_wrap_add #(
    parameter int             DBW    = 16,
    parameter logic [DBW-1:0] STK_LO = 16'h0100,
    parameter logic [DBW-1:0] STK_HI = 16'h01FF
) (
    input  logic [DBW-1:0] i_a,
    input  logic [DBW-1:0] i_b,
    output logic [DBW-1:0] o_result,
    output logic           o_below,
    output logic           o_above
);

    // Window size minus one; the window size is a power of two when folding is used
    localparam logic [DBW-1:0] SIZE_M1 = STK_HI - STK_LO;

    logic [DBW-1:0] w_sum;
    logic [DBW-1:0] w_off;
    logic           w_out;

    // Raw sum, out-of-window detect, and fold back into the window
    always_comb begin
        w_sum    = i_a + i_b;
        w_out    = (w_sum < STK_LO) || (w_sum > STK_HI);
        w_off    = (w_sum - STK_LO) & SIZE_M1;
        o_result = w_out ? (STK_LO + w_off) : w_sum;
        o_below  = w_out & i_b[DBW-1];
        o_above  = w_out & ~i_b[DBW-1];
    end

endmodule

// File: rtl/stack_ptr_unit.sv
// Registered stack pointer with multi-beat push/pull address sequencing,
// displacement/load updates and a bounded stack window (wrap or trap).
//
// Memory handshake: a beat transfers on a rising edge where addr_vld=1 and
// addr_rdy=1. Once addr_vld is raised, addr holds steady until that beat
// transfers or the burst aborts. addr_vld never drops without a transfer,
// except on reset or abort.
module stack_ptr_unit
    import stk_pkg::*;
#(
    parameter int             DBW    = 16,
    parameter logic [DBW-1:0] SP_RST = 16'h01FF,
    parameter logic [DBW-1:0] STK_LO = 16'h0100,
    parameter logic [DBW-1:0] STK_HI = 16'h01FF,
    parameter bit             WRAP   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic [2:0]      op,
    input  logic [1:0]      cnt,
    input  logic [DBW-1:0]  disp,
    input  logic [DBW-1:0]  ld_val,
    output logic [DBW-1:0]  addr,
    output logic            addr_vld,
    input  logic            addr_rdy,
    output logic [DBW-1:0]  sp,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            ovf,
    output logic            unf,
    input  logic            clr_flags,
    output stk_state_e      dbg_state
);

    localparam logic [DBW-1:0] ONE = {{(DBW-1){1'b0}}, 1'b1};

    stk_state_e     r_state;
    logic [DBW-1:0] r_sp;
    logic [DBW-1:0] r_addr;
    logic [1:0]     r_left;
    logic           r_addr_vld;
    logic           r_done;
    logic           r_err;
    logic           r_ovf;
    logic           r_unf;

    logic [DBW-1:0] w_add_a;
    logic [DBW-1:0] w_add_b;
    logic [DBW-1:0] w_add_res;
    logic           w_below;
    logic           w_above;
    logic           w_ld_ok;

    // Operand select for the shared adder. Push steps SP down by one. Pull
    // steps the current beat address up by one. Idle computes SP+disp for
    // add, or SP+1 for the first pull beat.
    always_comb begin
        w_add_a = r_sp;
        w_add_b = ONE;
        case (r_state)
            ST_PUSH: w_add_b = '1;
            ST_PULL: w_add_a = r_addr;
            default: begin
                if (op == OP_ADD) begin
                    w_add_b = disp;
                end
            end
        endcase
    end

    stk_wrap_add #(
        .DBW    (DBW),
        .STK_LO (STK_LO),
        .STK_HI (STK_HI)
    ) u_add (
        .i_a      (w_add_a),
        .i_b      (w_add_b),
        .o_result (w_add_res),
        .o_below  (w_below),
        .o_above  (w_above)
    );

    assign w_ld_ok = (ld_val >= STK_LO) && (ld_val <= STK_HI);

    // Control FSM: accepts requests in IDLE, sequences push/pull beats,
    // applies add/load in one edge, and maintains done/err and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sp       <= SP_RST;
            r_addr     <= SP_RST;
            r_left     <= 2'd0;
            r_addr_vld <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            // Clear first so that a set event later in this block wins
            if (clr_flags) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        case (op)
                            OP_PULL: begin
                                if (w_above && !WRAP) begin
                                    // First beat would leave the window: nothing issued
                                    r_unf  <= 1'b1;
                                    r_done <= 1'b1;
                                    r_err  <= 1'b1;
                                end else begin
                                    if (w_above) begin
                                        r_unf <= 1'b1;
                                    end
                                    r_addr     <= w_add_res;
                                    r_addr_vld <= 1'b1;
                                    r_left     <= cnt;
                                    r_state    <= ST_PULL;
                                end
                            end
                            OP_PUSH: begin
                                r_addr     <= r_sp;
                                r_addr_vld <= 1'b1;
                                r_left     <= cnt;
                                r_state    <= ST_PUSH;
                            end
                            OP_ADD: begin
                                r_done <= 1'b1;
                                if (w_below) begin
                                    r_ovf <= 1'b1;
                                end
                                if (w_above) begin
                                    r_unf <= 1'b1;
                                end
                                if (!(w_below || w_above) || WRAP) begin
                                    r_sp <= w_add_res;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                            OP_LOAD: begin
                                r_done <= 1'b1;
                                if (w_ld_ok) begin
                                    r_sp <= ld_val;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_PUSH: begin
                    if (addr_rdy) begin
                        if (w_below) begin
                            r_ovf <= 1'b1;
                        end
                        if (w_below && !WRAP) begin
                            // SP already sits at STK_LO; hold it and abort
                            r_state    <= ST_IDLE;
                            r_addr_vld <= 1'b0;
                            r_done     <= 1'b1;
                            r_err      <= 1'b1;
                        end else begin
                            r_sp <= w_add_res;
                            if (r_left == 2'd0) begin
                                r_state    <= ST_IDLE;
                                r_addr_vld <= 1'b0;
                                r_done     <= 1'b1;
                            end else begin
                                r_left <= r_left - 2'd1;
                                r_addr <= w_add_res;
                            end
                        end
                    end
                end
                ST_PULL: begin
                    if (addr_rdy) begin
                        r_sp <= r_addr;
                        if (r_left == 2'd0) begin
                            r_state    <= ST_IDLE;
                            r_addr_vld <= 1'b0;
                            r_done     <= 1'b1;
                        end else if (w_above && !WRAP) begin
                            // Next beat would leave the window: stop here
                            r_unf      <= 1'b1;
                            r_state    <= ST_IDLE;
                            r_addr_vld <= 1'b0;
                            r_done     <= 1'b1;
                            r_err      <= 1'b1;
                        end else begin
                            if (w_above) begin
                                r_unf <= 1'b1;
                            end
                            r_left <= r_left - 2'd1;
                            r_addr <= w_add_res;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_addr_vld <= 1'b0;
                end
            endcase
        end
    end

    assign addr      = r_addr;
    assign addr_vld  = r_addr_vld;
    assign sp        = r_sp;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign dbg_state = r_state;

endmodule
